// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell, one bit per clock, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.

module fa (
    output logic y,
    output logic cOut,
    input  logic A,
    input  logic B,
    input  logic C
);
    assign y    = A ^ B ^ C;
    assign cOut = (A & B) | (C & (A ^ B));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_q;
    logic [WIDTH-1:0] sum_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cout_q, busy_q, done_q;
    logic             fa_y, fa_co;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q;
`endif

    fa u_fa (fa_y, fa_co, a_sh_q[0], b_sh_q[0], carry_q);

    // New bit enters at the MSB so the LSB-first result lands in place after WIDTH shifts.
    assign sum_d = {fa_y, sum_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        busy_q  <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
                        ovf_q   <= 1'b0;
`endif
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= fa_co;
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        cout_q  <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
                        // carry into the MSB differs from carry out of it
                        ovf_q   <= carry_q ^ fa_co;
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8): stimulus pushes expected results,
// a monitor pops and compares on every done pulse.

module tb_serial_add_ctrl;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, start, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    // Independent reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic ci);
        exp_t e;
        logic [W:0] t;
        int ss;
        t    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        ss   = int'($signed(x)) + int'($signed(y)) + int'(ci);
        e.s  = t[W-1:0];
        e.c  = t[W];
        e.o  = (ss > 127 || ss < -128);
        return e;
    endfunction

    function automatic exp_t hand(logic [W-1:0] s, logic c, logic o);
        exp_t e;
        e.s = s; e.c = c; e.o = o;
        return e;
    endfunction

    // Monitor: compare whatever the DUT presents on each done pulse.
    always @(negedge clk) begin
        if (!reset) begin
            chk("busy_and_done_exclusive", {31'b0, busy & done}, 32'd0);
            if (done) begin
                n_done++;
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sum",  {24'b0, sum}, {24'b0, e.s});
                    chk("cout", {31'b0, cout}, {31'b0, e.c});
`ifdef SERIAL_ADD_OVF_EN
                    chk("ovf",  {31'b0, ovf}, {31'b0, e.o});
`endif
                end
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || done) && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (busy || done) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("scoreboard_drained", q.size(), 32'd0);
    endtask

    // Launch one addition from IDLE; expectation is pushed at issue.
    task automatic issue(logic [W-1:0] x, logic [W-1:0] y, logic ci, exp_t e);
        wait_idle();
        a = x; b = y; cin = ci; start = 1'b1;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = ~x; b = ~y; cin = ~ci;
    endtask

    initial begin
        int dn [3];
        int nd;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_sum",  {24'b0, sum},  32'd0);
        chk("rst_cout", {31'b0, cout}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_ovf",  {31'b0, ovf},  32'd0);
`endif
        // reset wins over a simultaneous start
        start = 1'b1; a = 8'h01; b = 8'h01;
        @(negedge clk);
        chk("rst_vs_start_busy", {31'b0, busy}, 32'd0);
        start = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", {31'b0, busy}, 32'd0);

        // Latency: accept at edge k, busy cycles k+1..k+W, done only in k+W+1.
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        q.push_back(hand(8'h10, 1'b0, 1'b0));
        for (int i = 1; i <= W + 2; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            chk("lat_busy", {31'b0, busy}, (i <= W) ? 32'd1 : 32'd0);
            chk("lat_done", {31'b0, done}, (i == W + 1) ? 32'd1 : 32'd0);
        end

        issue(8'hFF, 8'h01, 1'b0, hand(8'h00, 1'b1, 1'b0));
        issue(8'hFF, 8'hFF, 1'b1, hand(8'hFF, 1'b1, 1'b0));

        // start during RUN is ignored
        wait_idle();
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        q.push_back(hand(8'h46, 1'b0, 1'b0));
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (W + 4) @(negedge clk);
        wait_drain();

        // reset mid-run abandons the operation with no done pulse
        wait_idle();
        nd = n_done;
        a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
        repeat (4) begin
            @(negedge clk); start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_sum",  {24'b0, sum},  32'd0);
        chk("abort_cout", {31'b0, cout}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        @(negedge clk); reset = 1'b0;
        repeat (W + 4) @(negedge clk);
        chk("abort_no_done", n_done, nd);
        issue(8'hAA, 8'h55, 1'b1, hand(8'h00, 1'b1, 1'b0));
        wait_drain();

        // start held high: one operation every W+2 cycles
        wait_idle();
        a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
        repeat (3) q.push_back(hand(8'h07, 1'b0, 1'b0));
        nd = 0;
        for (int i = 1; i <= 3 * (W + 2); i++) begin
            @(negedge clk);
            if (done && nd < 3) begin dn[nd] = i; nd++; end
            if (i == 2 * (W + 2) + 1) start = 1'b0;
        end
        chk("held_done_count", nd, 32'd3);
        if (nd == 3) begin
            chk("held_first_done", dn[0], W + 1);
            chk("held_period_1", dn[1] - dn[0], W + 2);
            chk("held_period_2", dn[2] - dn[1], W + 2);
        end
        wait_drain();

`ifdef SERIAL_ADD_OVF_EN
        issue(8'h7F, 8'h01, 1'b0, hand(8'h80, 1'b0, 1'b1));
        issue(8'h80, 8'h80, 1'b0, hand(8'h00, 1'b1, 1'b1));
        issue(8'h05, 8'hFB, 1'b0, hand(8'h00, 1'b1, 1'b0));
`endif

        // Sweep of corner operands against the integer reference.
        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] bl [6];
            bl = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h5A};
            for (int j = 0; j < 6; j++) begin
                logic [W-1:0] x;
                x = W'(i * 17);
                issue(x, bl[j], 1'(j), model(x, bl[j], 1'(j)));
            end
        end
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller that reuses one instance of the team's single-bit full-adder cell `fa` to add two WIDTH-bit operands, one bit per clock, LSB first.
- Sequences operand shifting, the carry register and result assembly.
- Presents a start/busy/done handshake to the surrounding datapath.
- Trades latency for area where a single shared adder cell is preferred over a ripple-carry array.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- busy  output  1  high while the serial addition is in progress.
- done  output  1  one-cycle pulse; sum/cout are valid in this cycle.
- sum  output  WIDTH  result; held stable after done until the next accepted start.
- cout  output  1  carry-out of the MSB; held with sum.

Behaviour:
- One clock, one reset. Reset is synchronous and active-high; clock and reset ports are named clk and reset.
- Reset values: busy=0, done=0, sum=0, cout=0. State=IDLE, bit counter=0, carry register=0, operand shift registers=0.
- Datapath:
  - Internal regs a_sh, b_sh (WIDTH), carry (1), cnt (ceil(log2(WIDTH)) bits).
  - `fa` is instantiated once, port order (y, cOut, A, B, C), with A=a_sh[0], B=b_sh[0], C=carry.
- States:
  - IDLE:
    - busy=0.
    - If start=1: load a_sh=a, b_sh=b, carry=cin, cnt=0, sum=0, cout=0; go to RUN.
    - Else stay.
  - RUN:
    - busy=1.
    - Each cycle: sum <= {y, sum[WIDTH-1:1]}; carry <= cOut; a_sh and b_sh shift right by 1 (zero fill); cnt <= cnt+1.
    - When cnt==WIDTH-1: cout <= cOut and go to DONE.
  - DONE:
    - busy=0, done=1 for exactly this cycle; unconditionally return to IDLE next edge.
    - start asserted during DONE is ignored; the requester must hold or re-assert it in IDLE.
- Latency:
  - Start accepted at edge k. busy is high for cycles k+1..k+WIDTH.
  - done is high in cycle k+WIDTH+1, i.e. sampled high at edge k+WIDTH+1.
  - Throughput: one addition per WIDTH+2 cycles.
- start while busy (RUN) is ignored. Operand inputs a/b/cin may change freely after the accepting edge without affecting the result.
- sum and cout may hold partial values during RUN; they are defined only from the done cycle onward. After done they hold until the next accepted start clears them.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1), unsigned.
- Reset mid-operation: reset has priority in every state. Asserting reset in any RUN cycle abandons the operation next edge, with all outputs at reset values and no done pulse.
- Simultaneous reset and start: reset wins; start is not accepted.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - Adds output port ovf (output, 1 bit): signed two's-complement overflow.
  - In the last RUN cycle, ovf <= carry XOR cOut, i.e. carry into MSB XOR carry out of MSB.
  - ovf is 0 on reset and is cleared on accepted start. It is valid and held with sum/cout.
- Not defined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, a=8'h0F, b=8'h01, cin=0, start pulsed at edge k -> busy high cycles k+1..k+8; done in cycle k+9 only; sum=8'h10, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1. Also exhaustively compare all 2^17 combinations against a+b+cin.
- Start accepted with 8'h12+8'h34; at cycle k+3 drive start=1 with a=8'hFF, b=8'hFF -> ignored; result sum=8'h46, cout=0, and a single done pulse.
- Reset asserted at cycle k+4 of a run -> next edge busy=0, sum=0, cout=0, no done. A fresh start with 8'hAA+8'h55, cin=1 -> sum=8'h00, cout=1.
- start held high continuously -> a new operation is accepted in each IDLE cycle after DONE; done pulses every WIDTH+2 cycles; busy is never high during done.
- SERIAL_ADD_OVF_EN defined: 8'h7F+8'h01 -> sum=8'h80, ovf=1; 8'h80+8'h80 -> sum=8'h00, cout=1, ovf=1; 8'h05+8'hFB -> sum=8'h00, cout=1, ovf=0.
